// File: rtl/vreg_burst_scheduler.sv
// Round-robin burst scheduler in front of one vector register bank: grants a lane,
// then issues one auto-incrementing read or write beat per cycle until the burst ends.
module vreg_burst_scheduler #(
    parameter int unsigned NUM_PORT = 4,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned LEN_W    = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORT-1:0]          req_vld,
    input  logic [NUM_PORT-1:0]          req_write,
    input  logic [NUM_PORT*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORT*LEN_W-1:0]    req_len,
    input  logic [NUM_PORT*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORT-1:0]          req_ack,
    output logic [NUM_PORT-1:0]          beat_strobe,
    output logic [NUM_PORT-1:0]          done,
    output logic                         vreg_rd_en,
    output logic [ADDR_W-1:0]            vreg_rd_addr,
    output logic                         vreg_wr_en,
    output logic [ADDR_W-1:0]            vreg_wr_addr,
    output logic [DATA_W-1:0]            vreg_wr_data,
    output logic [NUM_PORT-1:0]          rsp_vld,
    output logic                         rsp_last,
    output logic                         busy
);

    localparam int unsigned PTR_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [NUM_PORT-1:0] rsp_vld_q, rsp_vld_d;
    logic                rsp_last_q, rsp_last_d;

    logic [PTR_W-1:0]    gnt, idx;
    logic [LEN_W-1:0]    gnt_len;
    logic                found;
    logic [NUM_PORT-1:0] ack_c, done_c, strobe_c;
    logic                rd_en_c, wr_en_c;

    // Arbitration, burst sequencing and read-response pipeline
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rsp_vld_d  = '0;
        rsp_last_d = 1'b0;
        gnt        = '0;
        idx        = '0;
        gnt_len    = '0;
        found      = 1'b0;
        ack_c      = '0;
        done_c     = '0;
        strobe_c   = '0;
        rd_en_c    = 1'b0;
        wr_en_c    = 1'b0;

        case (state_q)
            IDLE: begin
                for (int i = 0; i < int'(NUM_PORT); i++) begin
                    idx = PTR_W'((int'(ptr_q) + i) % int'(NUM_PORT));
                    if (!found && req_vld[idx]) begin
                        found = 1'b1;
                        gnt   = idx;
                    end
                end
                if (found) begin
                    ack_c[gnt] = 1'b1;
                    gnt_len    = req_len[int'(gnt)*int'(LEN_W) +: LEN_W];
                    owner_d    = gnt;
                    addr_d     = req_addr[int'(gnt)*int'(ADDR_W) +: ADDR_W];
                    cnt_d      = gnt_len;
                    wr_d       = req_write[gnt];
                    ptr_d      = (int'(gnt) == int'(NUM_PORT) - 1) ? '0 : gnt + PTR_W'(1);
                    if (gnt_len != '0) begin
                        state_d = BURST;
                    end else begin
                        done_c[gnt] = 1'b1;
                    end
                end
            end
            BURST: begin
                strobe_c[owner_q] = 1'b1;
                if (wr_q) begin
                    wr_en_c = 1'b1;
                end else begin
                    rd_en_c              = 1'b1;
                    rsp_vld_d[owner_q]   = 1'b1;
                    rsp_last_d           = (cnt_q == LEN_W'(1));
                end
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    done_c[owner_q] = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            rsp_vld_q  <= '0;
            rsp_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_last_q <= rsp_last_d;
        end
    end

    // Grant-side pulses come straight from the inputs, so hold them low while in reset
    assign req_ack      = ack_c & {NUM_PORT{reset}};
    assign done         = done_c & {NUM_PORT{reset}};
    assign beat_strobe  = strobe_c;
    assign vreg_rd_en   = rd_en_c;
    assign vreg_rd_addr = rd_en_c ? addr_q : '0;
    assign vreg_wr_en   = wr_en_c;
    assign vreg_wr_addr = wr_en_c ? addr_q : '0;
    assign vreg_wr_data = wr_en_c ? req_wdata[int'(owner_q)*int'(DATA_W) +: DATA_W] : '0;
    assign rsp_vld      = rsp_vld_q;
    assign rsp_last     = rsp_last_q;
    assign busy         = (state_q == BURST);

endmodule

// File: tb/tb_vreg_burst_scheduler.sv
// Directed bench for vreg_burst_scheduler: expected bank/handshake events are queued
// as requests are issued and checked by a negedge monitor as the DUT produces them.
module tb_vreg_burst_scheduler;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 64;
    localparam int unsigned LW = 7;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    req_vld;
    logic [NP-1:0]    req_write;
    logic [NP*AW-1:0] req_addr;
    logic [NP*LW-1:0] req_len;
    logic [NP*DW-1:0] req_wdata;
    logic [NP-1:0]    req_ack;
    logic [NP-1:0]    beat_strobe;
    logic [NP-1:0]    done;
    logic             vreg_rd_en;
    logic [AW-1:0]    vreg_rd_addr;
    logic             vreg_wr_en;
    logic [AW-1:0]    vreg_wr_addr;
    logic [DW-1:0]    vreg_wr_data;
    logic [NP-1:0]    rsp_vld;
    logic             rsp_last;
    logic             busy;

    vreg_burst_scheduler #(.NUM_PORT(NP), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .req_vld(req_vld), .req_write(req_write), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .req_ack(req_ack), .beat_strobe(beat_strobe), .done(done),
        .vreg_rd_en(vreg_rd_en), .vreg_rd_addr(vreg_rd_addr),
        .vreg_wr_en(vreg_wr_en), .vreg_wr_addr(vreg_wr_addr), .vreg_wr_data(vreg_wr_data),
        .rsp_vld(rsp_vld), .rsp_last(rsp_last), .busy(busy)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int cyc = 0;
    int wbase [NP];
    int wcnt  [NP];

    logic [NP-1:0]    exp_ack_q  [$];
    logic [NP-1:0]    exp_done_q [$];
    logic [AW-1:0]    exp_rd_q   [$];
    logic [AW+DW-1:0] exp_wr_q   [$];
    logic [NP:0]      exp_rsp_q  [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [DW-1:0] pat(input int p, input int j);
        return {8'(p), 24'hC0FFEE, 32'(j)};
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input bit wr, input int addr, input int len);
        req_vld[p]             = 1'b1;
        req_write[p]           = wr;
        req_addr[p*AW +: AW]   = AW'(addr);
        req_len[p*LW +: LW]    = LW'(len);
    endtask

    // Queue every event a complete burst should produce, in grant order
    task automatic push_burst(input int p, input bit wr, input int addr, input int len);
        logic [AW-1:0] a;
        exp_ack_q.push_back(onehot(p));
        exp_done_q.push_back(onehot(p));
        for (int j = 0; j < len; j++) begin
            a = AW'(addr + j);
            if (wr) exp_wr_q.push_back({a, pat(p, wbase[p] + j)});
            else begin
                exp_rd_q.push_back(a);
                exp_rsp_q.push_back({onehot(p), (j == len - 1)});
            end
        end
        wbase[p] += len;
    endtask

    task automatic wait_ack(input int p);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ack[p]) break;
        end
        if (k == 50) chk("ack_timeout", 128'(req_ack[p]), 128'(1));
    endtask

    // Requester model: each port advances its write element the cycle after a strobe
    initial begin
        logic [NP-1:0] s;
        for (int p = 0; p < NP; p++) begin
            wcnt[p] = 0;
            req_wdata[p*DW +: DW] = pat(p, 0);
        end
        forever begin
            @(negedge clk);
            s = beat_strobe;
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (s[p]) wcnt[p]++;
                req_wdata[p*DW +: DW] = pat(p, wcnt[p]);
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (vreg_rd_en || vreg_wr_en)
                chk("rd_wr_exclusive", 128'(vreg_rd_en & vreg_wr_en), 128'(0));
            if (req_ack != '0) begin
                if (exp_ack_q.size() == 0) chk("ack_unexpected", 128'(req_ack), 128'(0));
                else chk("ack", 128'(req_ack), 128'(exp_ack_q.pop_front()));
            end
            if (done != '0) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", 128'(done), 128'(0));
                else chk("done", 128'(done), 128'(exp_done_q.pop_front()));
            end
            if (vreg_rd_en) begin
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 128'(vreg_rd_en), 128'(0));
                else chk("rd_addr", 128'(vreg_rd_addr), 128'(exp_rd_q.pop_front()));
            end
            if (vreg_wr_en) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 128'(vreg_wr_en), 128'(0));
                else chk("wr_addr_data", 128'({vreg_wr_addr, vreg_wr_data}), 128'(exp_wr_q.pop_front()));
            end
            if (rsp_vld != '0) begin
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 128'(rsp_vld), 128'(0));
                else chk("rsp", 128'({rsp_vld, rsp_last}), 128'(exp_rsp_q.pop_front()));
            end else if (rsp_last) begin
                chk("rsp_last_orphan", 128'(rsp_last), 128'(0));
            end
        end
    end

    initial begin
        int ack_cyc;
        int last_cyc;
        int k;
        for (int p = 0; p < NP; p++) wbase[p] = 0;
        reset     = 1'b0;
        req_vld   = '0;
        req_write = '0;
        req_addr  = '0;
        req_len   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ack", 128'(req_ack), 128'(0));
        chk("rst_en", 128'({vreg_rd_en, vreg_wr_en}), 128'(0));
        chk("rst_rsp", 128'({rsp_vld, rsp_last}), 128'(0));
        reset = 1'b1;
        tick();

        // Reset mid-burst: write len 10, reset lands in beat 4
        set_req(0, 1'b1, 0, 10);
        exp_ack_q.push_back(4'b0001);
        for (int j = 0; j < 4; j++) exp_wr_q.push_back({AW'(j), pat(0, j)});
        wbase[0] += 4;
        @(negedge clk);
        chk("t1_ack", 128'(req_ack), 128'(4'b0001));
        tick();
        req_vld[0] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t1_strobe", 128'(beat_strobe), 128'(4'b0001));
            chk("t1_busy", 128'(busy), 128'(1));
            if (j < 3) tick();
        end
        #1 reset = 1'b0;
        #1;
        chk("t1_rst_outs", 128'({beat_strobe, done, vreg_wr_en, vreg_rd_en, busy}), 128'(0));
        chk("t1_rst_wdata", 128'(vreg_wr_data), 128'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        set_req(0, 1'b0, 8, 1);
        set_req(1, 1'b0, 9, 1);
        push_burst(0, 1'b0, 8, 1);
        push_burst(1, 1'b0, 9, 1);
        @(negedge clk);
        chk("t1_regrant_ptr0", 128'(req_ack), 128'(4'b0001));
        tick();
        req_vld[0] = 1'b0;
        wait_ack(1);
        tick();
        req_vld[1] = 1'b0;
        repeat (3) tick();

        // Single read burst, port 1
        set_req(1, 1'b0, 5, 3);
        push_burst(1, 1'b0, 5, 3);
        @(negedge clk);
        chk("t2_ack", 128'(req_ack), 128'(4'b0010));
        chk("t2_busy_t0", 128'(busy), 128'(0));
        tick();
        req_vld[1] = 1'b0;
        @(negedge clk);
        chk("t2_busy_t1", 128'(busy), 128'(1));
        chk("t2_rd_t1", 128'({vreg_rd_en, vreg_rd_addr}), 128'({1'b1, 6'd5}));
        tick();
        @(negedge clk);
        chk("t2_rsp_t2", 128'({rsp_vld, rsp_last}), 128'({4'b0010, 1'b0}));
        tick();
        @(negedge clk);
        chk("t2_done_t3", 128'(done), 128'(4'b0010));
        chk("t2_busy_t3", 128'(busy), 128'(1));
        tick();
        @(negedge clk);
        chk("t2_rsp_last_t4", 128'({rsp_vld, rsp_last}), 128'({4'b0010, 1'b1}));
        chk("t2_idle_t4", 128'({busy, vreg_rd_en}), 128'(0));
        tick();

        // Write burst across the address wrap, port 2
        set_req(2, 1'b1, 62, 4);
        push_burst(2, 1'b1, 62, 4);
        @(negedge clk);
        chk("t3_ack", 128'(req_ack), 128'(4'b0100));
        tick();
        req_vld[2] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t3_strobe", 128'(beat_strobe), 128'(4'b0100));
            tick();
        end
        @(negedge clk);
        chk("t3_after", 128'({beat_strobe, vreg_wr_en}), 128'(0));
        tick();

        // Zero length on port 3, then all ports request on the very next cycle
        set_req(3, 1'b0, 0, 0);
        push_burst(3, 1'b0, 0, 0);
        @(negedge clk);
        chk("t5_ack", 128'(req_ack), 128'(4'b1000));
        chk("t5_done", 128'(done), 128'(4'b1000));
        chk("t5_no_access", 128'({vreg_rd_en, vreg_wr_en, busy}), 128'(0));
        last_cyc = cyc;
        tick();
        for (int p = 0; p < NP; p++) set_req(p, 1'b0, p * 16, 2);
        for (int g = 0; g < 5; g++) push_burst(g % NP, 1'b0, (g % NP) * 16, 2);

        // Round-robin: expected order 0,1,2,3,0 with 3-cycle spacing
        for (int g = 0; g < 5; g++) begin
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (req_ack != '0) break;
            end
            ack_cyc = cyc;
            chk("t4_grant", 128'(req_ack), 128'(onehot(g % NP)));
            chk(g == 0 ? "t5_next_cycle" : "t4_spacing", 128'(ack_cyc - last_cyc),
                128'(g == 0 ? 1 : 3));
            last_cyc = ack_cyc;
            if (g < 4) tick();
        end
        tick();
        req_vld = '0;
        repeat (6) tick();

        chk("q_ack_left", 128'(exp_ack_q.size()), 128'(0));
        chk("q_done_left", 128'(exp_done_q.size()), 128'(0));
        chk("q_rd_left", 128'(exp_rd_q.size()), 128'(0));
        chk("q_wr_left", 128'(exp_wr_q.size()), 128'(0));
        chk("q_rsp_left", 128'(exp_rsp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vreg_burst_scheduler.md
Name: vreg_burst_scheduler

Overview:
- Per-vector-register scheduler placed in front of one vector register bank.
- Shares the bank among NUM_PORT lane requesters using round-robin arbitration.
- Once a request is granted, the bank stays locked to that requester for the whole burst of access_length beats.
- Generates one read or write beat per cycle with auto-incrementing address, and returns read responses aligned to the bank's 1-cycle read latency.

Parameters:
NUM_PORT, 4, number of requesting lanes
ADDR_W, 6, vector register address width (depth 2**ADDR_W)
DATA_W, 64, vector element width
LEN_W, 7, burst length field width (max 127 beats)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
req_vld  input  NUM_PORT  per-port request valid (level, held until req_ack)
req_write  input  NUM_PORT  1=write burst, 0=read burst
req_addr  input  NUM_PORT*ADDR_W  per-port burst start address
req_len  input  NUM_PORT*LEN_W  per-port beat count
req_wdata  input  NUM_PORT*DATA_W  per-port current write element
req_ack  output  NUM_PORT  one-cycle pulse: request accepted
beat_strobe  output  NUM_PORT  one-cycle pulse per issued beat of the owning port
done  output  NUM_PORT  one-cycle pulse on the final beat (or on ack when len=0)
vreg_rd_en  output  1  bank read enable
vreg_rd_addr  output  ADDR_W  bank read address
vreg_wr_en  output  1  bank write enable
vreg_wr_addr  output  ADDR_W  bank write address
vreg_wr_data  output  DATA_W  bank write data
rsp_vld  output  NUM_PORT  read data valid for port (1 cycle after read beat)
rsp_last  output  1  qualifies rsp_vld: final element of burst
busy  output  1  high in BURST state

Behaviour:
- Reset (async, active-low): state=IDLE; RR pointer=0 (port 0 has highest priority); every output 0. An in-flight burst is dropped with no done pulse.
- FSM has two states, IDLE and BURST.
- IDLE:
  - If any req_vld is set, grant the first set port searching from ptr, ptr+1, …, wrapping modulo NUM_PORT.
  - Pulse req_ack[g] in that cycle.
  - Latch owner=g, addr=req_addr[g], cnt=req_len[g], wr=req_write[g].
  - Set ptr=(g+1) mod NUM_PORT.
  - If req_len[g]!=0, go to BURST. If req_len[g]==0, pulse done[g] in the same cycle as req_ack, make no bank access and stay in IDLE.
  - No bank enables are ever asserted in IDLE.
- BURST (one beat per cycle):
  - Read beat: vreg_rd_en=1, vreg_rd_addr=addr.
  - Write beat: vreg_wr_en=1, vreg_wr_addr=addr, vreg_wr_data=req_wdata[owner] (combinational pass-through).
  - beat_strobe[owner]=1. The requester advances req_wdata on the cycle after the strobe.
  - addr <= addr+1, wrapping 2**ADDR_W-1 -> 0. cnt <= cnt-1.
  - When cnt==1: pulse done[owner], return to IDLE.
  - After each burst there is a one-cycle IDLE bubble before the next grant. Back-to-back bursts therefore run at len+1 cycles each.
- Read response: rsp_vld[owner] is registered one cycle after each read beat. rsp_last is asserted with the response for the final beat. rsp_vld stays correct even if reset is not asserted and the state has already returned to IDLE.
- Input changes during BURST:
  - req_vld, req_addr, req_len and req_write of all ports are ignored; the burst is committed.
  - Deasserting req_vld[owner] mid-burst does not stop it.
- Simultaneity:
  - A port re-requesting in the cycle it receives done is only considered at the next IDLE cycle.
  - The advanced ptr gives the other ports priority over it.
- Exactly one of vreg_rd_en and vreg_wr_en is asserted per beat; they are never both high.
- cnt is LEN_W bits wide; a length of 2**LEN_W-1 yields exactly that many beats.

Test Plan:
1. Reset mid-burst: port 0 write, len=10, assert reset at beat 4 -> all outputs 0 immediately, no done; after release, port 0 re-request is granted with ptr=0.
2. Single read: port 1, addr=5, len=3, read -> req_ack[1] at T0; rd_addr 5,6,7 at T1–T3; done[1] at T3; rsp_vld[1] at T2–T4; rsp_last at T4; busy high T1–T3.
3. Address wrap: port 2 write, addr=62, len=4, ADDR_W=6 -> wr_addr 62,63,0,1; wr_data follows req_wdata[2] each beat; beat_strobe[2] on 4 consecutive cycles.
4. Round-robin fairness: all 4 ports request continuously with len=2, starting from ptr=0 -> grant order 0,1,2,3,0; each burst takes 3 cycles; no port is granted twice before all others.
5. Zero length: port 3 len=0 alone -> req_ack[3] and done[3] in the same cycle; no rd_en/wr_en; ptr=0 afterwards; the next request is granted the following cycle.
